// File: rtl/inst_rx_if.sv
// Instruction receiver bus: the instruction word and OFIFO status go in,
// the registered control word and the run-tracking status come out.
// The optional err_cnt signal exists only when INST_RX_ERR_CNT_EN is defined.
interface inst_rx_if;
    logic [33:0] inst;
    logic        ofifo_valid;
    logic [33:0] ctrl;
    logic [2:0]  phase;
    logic [5:0]  wr_cnt;
    logic [3:0]  acc_cnt;
    logic        acc_done;
    logic        err;
`ifdef INST_RX_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    modport master (
        output inst, ofifo_valid,
        input  ctrl, phase, wr_cnt, acc_cnt, acc_done, err
`ifdef INST_RX_ERR_CNT_EN
        , input err_cnt
`endif
    );

    modport slave (
        input  inst, ofifo_valid,
        output ctrl, phase, wr_cnt, acc_cnt, acc_done, err
`ifdef INST_RX_ERR_CNT_EN
        , output err_cnt
`endif
    );
endinterface

// File: rtl/inst_rx.sv
// inst_rx: registers the 34-bit instruction word, tracks the current phase,
// counts psum writes in an ORD run and accumulation reads in an ACC group,
// and raises a sticky error on protocol violations.
// Optional feature macro: INST_RX_ERR_CNT_EN adds an 8-bit saturating
// count of cycles that contained at least one violation.
module inst_rx #(
    parameter int len_kij = 9,
    parameter int len_nij = 36
) (
    input  logic     clk,
    input  logic     reset,
    inst_rx_if.slave bus
);
    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_XWR  = 3'd1;
    localparam logic [2:0] PH_FILL = 3'd2;
    localparam logic [2:0] PH_LOAD = 3'd3;
    localparam logic [2:0] PH_EXEC = 3'd4;
    localparam logic [2:0] PH_ORD  = 3'd5;
    localparam logic [2:0] PH_ACC  = 3'd6;

    // Legacy reset word for the control output.
    localparam logic [33:0] CTRL_RST = 34'h3_0008_0000;
    localparam logic [3:0]  LEN_KIJ  = 4'(len_kij);
    localparam logic [5:0]  LEN_NIJ  = 6'(len_nij);

    logic        f_acc, f_cen_pmem, f_wen_pmem, f_cen_xmem, f_wen_xmem;
    logic        f_ofifo_rd, f_ififo_wr, f_ififo_rd, f_l0_rd, f_l0_wr;
    logic        f_execute, f_load;

    assign f_acc      = bus.inst[33];
    assign f_cen_pmem = bus.inst[32];
    assign f_wen_pmem = bus.inst[31];
    assign f_cen_xmem = bus.inst[19];
    assign f_wen_xmem = bus.inst[18];
    assign f_ofifo_rd = bus.inst[6];
    assign f_ififo_wr = bus.inst[5];
    assign f_ififo_rd = bus.inst[4];
    assign f_l0_rd    = bus.inst[3];
    assign f_l0_wr    = bus.inst[2];
    assign f_execute  = bus.inst[1];
    assign f_load     = bus.inst[0];

    logic [33:0] ctrl_reg;
    logic [2:0]  phase_reg, phase_next;
    logic [5:0]  wr_cnt_reg;
    logic [3:0]  acc_cnt_reg;
    logic [3:0]  acc_inc;
    logic        acc_done_reg;
    logic        err_reg;
    logic        psum_wr;
    logic        ord_entry;
    logic        ord_exit_short;
    logic        acc_break;
    logic        any_viol;

    // Phase decode: the first matching instruction class wins.
    always_comb begin
        phase_next = PH_IDLE;
        if (f_acc)                          phase_next = PH_ACC;
        else if (f_ofifo_rd)                phase_next = PH_ORD;
        else if (f_execute || f_l0_rd)      phase_next = PH_EXEC;
        else if (f_load || f_ififo_rd)      phase_next = PH_LOAD;
        else if (f_l0_wr || f_ififo_wr)     phase_next = PH_FILL;
        else if (!f_cen_xmem && !f_wen_xmem) phase_next = PH_XWR;
    end

    assign psum_wr        = f_ofifo_rd && !f_cen_pmem && !f_wen_pmem;
    assign ord_entry      = (phase_next == PH_ORD) && (phase_reg != PH_ORD);
    // An ORD run closes when the next phase leaves ORD; it must have
    // written exactly one full nij pass.
    assign ord_exit_short = (phase_reg == PH_ORD) && (phase_next != PH_ORD)
                            && (wr_cnt_reg != LEN_NIJ);
    assign acc_break      = !f_acc && (acc_cnt_reg != 4'd0);
    assign acc_inc        = acc_cnt_reg + 4'd1;

    // All violation sources merge into one per-cycle flag.
    always_comb begin
        any_viol = (f_load && f_execute)
                 | (f_l0_wr && f_l0_rd)
                 | (f_ififo_wr && f_ififo_rd)
                 | (f_acc && !f_cen_pmem && !f_wen_pmem)
                 | (f_ofifo_rd && !bus.ofifo_valid)
                 | acc_break
                 | ord_exit_short;
    end

    // Control word and phase both register on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg  <= CTRL_RST;
            phase_reg <= PH_IDLE;
        end else begin
            ctrl_reg  <= bus.inst;
            phase_reg <= phase_next;
        end
    end

    // Psum write counter: restarts on ORD entry, holds between runs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_reg <= 6'd0;
        end else if (ord_entry) begin
            wr_cnt_reg <= psum_wr ? 6'd1 : 6'd0;
        end else if (psum_wr && (wr_cnt_reg != 6'd63)) begin
            wr_cnt_reg <= wr_cnt_reg + 6'd1;
        end
    end

    // Accumulation group counter with a completion pulse on the kij-th read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_cnt_reg  <= 4'd0;
            acc_done_reg <= 1'b0;
        end else begin
            acc_done_reg <= 1'b0;
            if (f_acc) begin
                if (acc_inc == LEN_KIJ) begin
                    acc_cnt_reg  <= 4'd0;
                    acc_done_reg <= 1'b1;
                end else begin
                    acc_cnt_reg <= acc_inc;
                end
            end else begin
                acc_cnt_reg <= 4'd0;
            end
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         err_reg <= 1'b0;
        else if (any_viol) err_reg <= 1'b1;
    end

    assign bus.ctrl     = ctrl_reg;
    assign bus.phase    = phase_reg;
    assign bus.wr_cnt   = wr_cnt_reg;
    assign bus.acc_cnt  = acc_cnt_reg;
    assign bus.acc_done = acc_done_reg;
    assign bus.err      = err_reg;

`ifdef INST_RX_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // Saturating count of cycles with at least one violation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt_reg <= 8'd0;
        else if (any_viol && (err_cnt_reg != 8'hFF))
            err_cnt_reg <= err_cnt_reg + 8'd1;
    end

    assign bus.err_cnt = err_cnt_reg;
`endif
endmodule
